// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the mac_seq job sequencer.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CALC = 2'd2,
        RESP = 2'd3
    } mac_seq_state_t;

    // Widest accumulator the delta helper supports.
    localparam int unsigned DELTA_MAX_W = 64;

    // Modular difference cur - base, reduced to 'width' bits.
    // Callers zero-extend their operands to 64 bits and truncate the result back.
    // Two's-complement subtraction gives the right answer across an accumulator wrap.
    function automatic logic [DELTA_MAX_W-1:0] mod_delta(
        input logic [DELTA_MAX_W-1:0] cur,
        input logic [DELTA_MAX_W-1:0] base,
        input int unsigned            width
    );
        logic [DELTA_MAX_W-1:0] mask;
        if (width >= DELTA_MAX_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        return (cur - base) & mask;
    endfunction

endpackage

// File: rtl/mac_seq_mac.sv
// Accumulating multiply unit: out += a*b on every enabled cycle.
// The accumulator wraps modulo 2^WIDTH and is never cleared between jobs.
module mac #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [WIDTH/2-1:0] a,
    input  logic [WIDTH/2-1:0] b,
    output logic [WIDTH-1:0]   out
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] prod;

    // Unsigned product at full accumulator width, then accumulate when enabled.
    always_comb begin
        prod  = {{(WIDTH/2){1'b0}}, a} * {{(WIDTH/2){1'b0}}, b};
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + prod;
        end
    end

    // Accumulator register; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out = acc_q;

endmodule

// File: rtl/mac_seq.sv
// Job sequencer for a single accumulating mac unit.
// Each job reports the accumulator delta over its operand pairs,
// so the mac is never cleared between jobs.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH/2-1:0] op_a,
    input  logic [WIDTH/2-1:0] op_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data
);

    mac_seq_state_t   state_q;
    mac_seq_state_t   state_d;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] base_d;
    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] remaining_d;
    logic [WIDTH-1:0] res_data_q;
    logic [WIDTH-1:0] res_data_d;

    logic             idle_st;
    logic             op_fire;
    logic             mac_en;
    logic [WIDTH-1:0] mac_out;

    // Operands go straight to the mac; only the enable is qualified by the handshake.
    mac #(
        .WIDTH (WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .a     (op_a),
        .b     (op_b),
        .out   (mac_out)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN/CALC -> CALC -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_len != '0) ? RUN : CALC;
                end
            end
            RUN: begin
                if (op_fire && (remaining_q == LEN_W'(1))) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state.
    // IDLE is the reset state, so cmd_ready is additionally held low while reset
    // is asserted; it rises as soon as reset is released.
    always_comb begin
        idle_st   = (state_q == IDLE);
        cmd_ready = idle_st & reset;
        op_ready  = (state_q == RUN);
        res_valid = (state_q == RESP);
        op_fire   = op_ready & op_valid;
        mac_en    = op_fire;
    end

    // Datapath next values: snapshot base and length on accept, count pairs, form the delta.
    always_comb begin
        base_d      = base_q;
        remaining_d = remaining_q;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    base_d      = mac_out;
                    remaining_d = cmd_len;
                end
            end
            RUN: begin
                if (op_fire) begin
                    remaining_d = remaining_q - LEN_W'(1);
                end
            end
            CALC: begin
                res_data_d = WIDTH'(mod_delta(64'(mac_out), 64'(base_q), WIDTH));
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q      <= '0;
            remaining_q <= '0;
            res_data_q  <= '0;
        end else begin
            base_q      <= base_d;
            remaining_q <= remaining_d;
            res_data_q  <= res_data_d;
        end
    end

    assign res_data = res_data_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: directed vector table, hand-written
// backpressure and mid-job reset sequences, then randomized jobs checked
// against a plain sum-of-products reference.
module tb_mac_seq;

    localparam int WIDTH = 16;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [7:0]       op_a = '0;
    logic [7:0]       op_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;

    int n_cmp  = 0;
    int n_fail = 0;

    int ja[256];
    int jb[256];

    typedef struct {
        string name;
        int    len;
        int    a[4];
        int    b[4];
        int    exp;
    } vec_t;

    vec_t tbl[5];

    mac_seq #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: the job result is simply the sum of products mod 2^WIDTH.
    function automatic int ref_sum(input int len);
        int s;
        s = 0;
        for (int i = 0; i < len; i++) begin
            s = s + ja[i] * jb[i];
        end
        return s % 65536;
    endfunction

    // Run one job from ja/jb. Called and returning at a negedge.
    task automatic run_job(input string tag, input int len, input int max_gap,
                           input int stall, input int exp);
        int         to;
        int         gap;
        logic [15:0] held;
        to = 0;
        while (!cmd_ready && to < 50) begin
            advance();
            to++;
        end
        check({tag, " cmd_ready_wait"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        advance();
        cmd_valid = 1'b0;
        if (len == 0) begin
            check({tag, " zl_op_ready_n1"}, 32'(op_ready), 0);
            check({tag, " zl_res_valid_n1"}, 32'(res_valid), 0);
            advance();
            check({tag, " zl_op_ready_n2"}, 32'(op_ready), 0);
            check({tag, " zl_res_valid_n2"}, 32'(res_valid), 1);
        end else begin
            check({tag, " run_start"}, 32'(op_ready), 1);
            for (int i = 0; i < len; i++) begin
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                repeat (gap) begin
                    check({tag, " gap_no_result"}, 32'(res_valid), 0);
                    advance();
                end
                op_valid = 1'b1;
                op_a     = 8'(ja[i]);
                op_b     = 8'(jb[i]);
                to = 0;
                while (!op_ready && to < 20) begin
                    advance();
                    to++;
                end
                check({tag, " op_ready"}, 32'(op_ready), 1);
                advance();
                op_valid = 1'b0;
                if (i == len - 1) begin
                    check({tag, " calc_no_valid"}, 32'(res_valid), 0);
                    advance();
                    check({tag, " res_valid_fire+2"}, 32'(res_valid), 1);
                end
            end
        end
        held = res_data;
        for (int s = 0; s < stall; s++) begin
            check({tag, " stall_valid"}, 32'(res_valid), 1);
            check({tag, " stall_data"}, 32'(res_data), 32'(held));
            check({tag, " stall_cmd_ready"}, 32'(cmd_ready), 0);
            advance();
        end
        check({tag, " res_valid"}, 32'(res_valid), 1);
        check({tag, " res_data"}, 32'(res_data), exp);
        $display("job %s len=%0d gap<=%0d stall=%0d res=%0d exp=%0d",
                 tag, len, max_gap, stall, res_data, exp);
        res_ready = 1'b1;
        advance();
        res_ready = 1'b0;
        check({tag, " post_res_valid"}, 32'(res_valid), 0);
        check({tag, " post_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        int len;

        tbl[0] = '{name: "basic",    len: 3, a: '{2, 4, 1, 0},   b: '{3, 5, 1, 0},   exp: 27};
        tbl[1] = '{name: "nzbase",   len: 2, a: '{10, 1, 0, 0},  b: '{10, 2, 0, 0},  exp: 102};
        tbl[2] = '{name: "prewrap",  len: 2, a: '{250, 50, 0, 0}, b: '{250, 50, 0, 0}, exp: 65000};
        tbl[3] = '{name: "wrap",     len: 2, a: '{255, 1, 0, 0}, b: '{255, 1, 0, 0}, exp: 65026};
        tbl[4] = '{name: "zerolen",  len: 0, a: '{0, 0, 0, 0},   b: '{0, 0, 0, 0},   exp: 0};

        // Reset state.
        #2;
        check("rst cmd_ready", 32'(cmd_ready), 0);
        check("rst op_ready", 32'(op_ready), 0);
        check("rst res_valid", 32'(res_valid), 0);
        check("rst res_data", 32'(res_data), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        advance();
        check("post_rst cmd_ready", 32'(cmd_ready), 1);

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                ja[i] = tbl[v].a[i];
                jb[i] = tbl[v].b[i];
            end
            run_job(tbl[v].name, tbl[v].len, 0, 0, tbl[v].exp);
        end

        // Backpressure: operand gaps up to 3 cycles, result stalled 5 cycles.
        ja[0] = 7;  jb[0] = 11;
        ja[1] = 8;  jb[1] = 12;
        ja[2] = 9;  jb[2] = 13;
        ja[3] = 10; jb[3] = 14;
        run_job("backpressure", 4, 3, 5, 430);

        // Randomized jobs against the reference sum.
        for (int j = 0; j < 30; j++) begin
            len = int'($urandom_range(6, 0));
            for (int i = 0; i < len; i++) begin
                ja[i] = int'($urandom_range(255, 0));
                jb[i] = int'($urandom_range(255, 0));
            end
            run_job($sformatf("rand%0d", j), len, 2, int'($urandom_range(3, 0)), ref_sum(len));
        end

        // Make sure res_data is nonzero before the mid-job reset.
        ja[0] = 9; jb[0] = 9;
        run_job("pre_reset", 1, 0, 0, 81);

        // Reset mid-RUN after 2 of 5 pairs.
        cmd_valid = 1'b1;
        cmd_len   = 8'd5;
        advance();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid = 1'b1;
            op_a     = 8'(i + 20);
            op_b     = 8'(i + 30);
            check("midrun op_ready", 32'(op_ready), 1);
            advance();
        end
        op_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrun_rst cmd_ready", 32'(cmd_ready), 0);
        check("midrun_rst op_ready", 32'(op_ready), 0);
        check("midrun_rst res_valid", 32'(res_valid), 0);
        check("midrun_rst res_data", 32'(res_data), 0);
        $display("job midrun_reset len=5 fired=2 outputs cleared");
        for (int i = 0; i < 3; i++) begin
            advance();
            check("in_rst res_valid", 32'(res_valid), 0);
        end
        reset = 1'b1;
        advance();
        check("after_rst cmd_ready", 32'(cmd_ready), 1);
        check("after_rst res_valid", 32'(res_valid), 0);
        ja[0] = 3; jb[0] = 7;
        run_job("after_reset", 1, 0, 0, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
# mac_seq

Job sequencer for a single accumulating `mac` unit. It accepts dot-product commands of a given length and streams operand pairs into the MAC under a valid/ready handshake. It returns each job's result as the accumulator delta over the job, so the MAC never needs clearing between jobs. It sits between the operand fetch logic and result consumers in the compute datapath.

## Interface
- `WIDTH`, default 16: result and accumulator width; operands are `WIDTH/2` bits; must be even and ≥ 4.
- `LEN_W`, default 8: width of the job-length field; a job has at most 2^LEN_W−1 pairs.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; also drives the internal `mac` reset.
- `cmd_valid`  in  1  job command valid.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_len`  in  LEN_W  number of operand pairs in the job; 0 is legal.
- `op_valid`  in  1  operand pair valid.
- `op_ready`  out  1  block can accept an operand pair.
- `op_a`  in  WIDTH/2  operand a, unsigned.
- `op_b`  in  WIDTH/2  operand b, unsigned.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  WIDTH  job result: sum of `op_a*op_b` over the job, mod 2^WIDTH.

## Operation
- FSM states: IDLE, RUN, CALC, RESP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`: capture `base` ← `mac.out` and `remaining` ← `cmd_len`.
  - Go to RUN if `cmd_len`≠0, else go to CALC.
- **RUN:**
  - `op_ready`=1.
  - A fire is `op_valid & op_ready`. A fire drives `mac.en`=1 and connects `mac.a`/`mac.b` combinationally to `op_a`/`op_b`.
  - Each fire decrements `remaining`. The fire with `remaining`==1 goes to CALC.
  - With `op_valid` low, `mac.en`=0 and the state holds.
- **CALC:**
  - One cycle. `res_data` ← `mac.out − base` (WIDTH-bit modular subtract).
  - Go to RESP.
- **RESP:**
  - `res_valid`=1; `res_data` held stable.
  - On `res_ready`, go to IDLE.
- `cmd_ready`, `op_ready` and `res_valid` are mutually exclusive. No command is accepted until the previous result is consumed.
- `mac.en` is 0 outside RUN fires. `mac.out` is therefore constant in IDLE, CALC and RESP.
- **Arithmetic:**
  - Products are unsigned, WIDTH bits.
  - The accumulator wraps modulo 2^WIDTH.
  - Delta subtraction is correct across accumulator wrap, provided the job's true sum is < 2^WIDTH. A job sum ≥ 2^WIDTH is reported mod 2^WIDTH; this is not an error.
- **Reset (any state, including mid-RUN):**
  - All outputs are 0: `cmd_ready`=0 during reset and 1 on the first cycle after release.
  - `state`=IDLE; `base`, `remaining` and `res_data` = 0; MAC accumulator = 0.
  - The in-flight job is discarded and no result is emitted.

## Timing
- `cmd_ready`, `op_ready` and `res_valid` are decoded from registered state only; none depends combinationally on an input.
- Command accept at edge N: if `cmd_len`≠0, RUN starts at cycle N+1 and the first pair can fire in that cycle.
- Last operand fire at edge M: `mac.out` is final after M, CALC is the cycle after M, and `res_valid` rises at edge M+2.
- `cmd_len`=0: accept at edge N, `res_valid`=1 from edge N+2, `res_data`=0.
- Throughput: one pair per cycle in RUN. Per-job overhead is 3 cycles (IDLE accept, CALC, RESP) with `res_ready` tied high.
- Back-to-back: the RESP handshake at edge K returns to IDLE, so the next command is accepted no earlier than edge K+1.

## Structure
- `mac_seq_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, CALC, RESP} mac_seq_state_t`.
  - A WIDTH-agnostic helper function for the modular delta.
- One sub-module: the team's `mac` (parameter `WIDTH`), instantiated as `u_mac`. Its `reset` is tied directly to the block `reset`, never gated.
- The FSM, `remaining` counter, `base` register and result register live in `mac_seq`.

## Test plan
- **Basic job:** reset, then cmd len 3, pairs (2,3), (4,5), (1,1) with `res_ready`=1.
  - Required: `res_data`=27.
  - Required: `res_valid` rises 2 cycles after the third fire.
- **Nonzero base:** after the job above, cmd len 2, pairs (10,10), (1,2).
  - Required: `res_data`=102, independent of the accumulator value 27.
- **Wrap:** WIDTH=16, start from an accumulator near the top (e.g. preceding jobs totalling 65000).
  - Next job len 2, pairs (255,255), (1,1).
  - Required: `res_data`=65026.
- **Zero length:** cmd len 0.
  - Required: `op_ready` never asserts.
  - Required: `res_valid` at accept+2 with `res_data`=0.
- **Backpressure:** len 4, with `op_valid` gaps of 0–3 cycles.
  - Hold `res_ready` low for 5 cycles.
  - Required: correct sum; `res_valid` and `res_data` stable while stalled.
  - Required: `cmd_ready`=0 until `res_ready`.
- **Reset mid-RUN:** assert `reset` after 2 of 5 pairs.
  - Required: all outputs 0 immediately and no result emitted.
  - Required: the next job len 1, pair (3,7), returns 21.
